ndata_packet_arbiter: RTL and testbench
=======================================

Name: ndata_packet_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one ndata stream sink between NUM_INPUTS ndata sources.
- Typical sink is a width converter or DMA writer.
- Grant is held from the first accepted beat until the beat with last=1; packets never interleave.
- Output is registered: one pipeline stage, full throughput.

Parameters:
- data_t, logic[31:0], element type carried on all streams.
- NUM_INPUTS, 4, number of requesting streams; >=2, power of two not required.
- NUM_ELEMENTS, 8, elements per beat on every input and on the output.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous, active-low reset
- in_data  in  NUM_INPUTS x NUM_ELEMENTS x data_t  per-input beat data
- in_keep  in  NUM_INPUTS x NUM_ELEMENTS  per-element valid mask
- in_last  in  NUM_INPUTS  end-of-packet marker
- in_valid  in  NUM_INPUTS  beat valid
- in_ready  out  NUM_INPUTS  beat accepted when valid&ready
- out_data  out  NUM_ELEMENTS x data_t  merged stream data
- out_keep  out  NUM_ELEMENTS  merged keep
- out_last  out  1  merged last
- out_valid  out  1  merged valid
- out_ready  in  1  sink backpressure
- out_src  out  $clog2(NUM_INPUTS)  index of the input that produced the current output beat

Behaviour:
- Reset values:
  - out_valid=0, out_last=0, out_keep=0, out_src=0.
  - FSM=IDLE, rr_ptr=0.
  - out_data is don't-care.
- Output register:
  - load_en = !out_valid | out_ready.
  - A beat is captured on the cycle it is accepted, so input-to-output latency is 1 cycle.
  - An accept on output and a capture of a new beat may occur in the same cycle; there are no bubbles.
- in_ready[i] = load_en & (i == sel) & active, where sel and active are defined per state. All other in_ready bits are 0.
- IDLE state:
  - sel is the first i with in_valid[i]=1, searching from rr_ptr upward with modulo wrap.
  - active = any in_valid.
  - Selection is combinational; the first beat transfers in the same cycle the request is seen.
  - Accepted beat with last=0: go to LOCKED, set grant=sel.
  - Accepted beat with last=1 (single-beat packet): stay in IDLE, set rr_ptr = (sel+1) mod NUM_INPUTS.
- LOCKED state:
  - sel = grant; active = 1.
  - Other inputs are ignored even when the granted input deasserts valid mid-packet.
  - Accepted beat with last=1: go to IDLE, set rr_ptr = (grant+1) mod NUM_INPUTS.
- rr_ptr wrap: grant = NUM_INPUTS-1 sets rr_ptr to 0.
- Fairness: a continuously requesting input waits at most NUM_INPUTS-1 packets.
- Backpressure (out_ready=0 with out_valid=1):
  - All in_ready=0.
  - Output register, FSM and rr_ptr hold.
- Keep/data pass through unchanged. The arbiter does not check keep and does not enforce last semantics.
- Reset mid-packet:
  - The partial packet is dropped from the arbiter state.
  - The source must also be reset; the arbiter does not re-synchronise to a partial packet.
- Protocol: an input must not drop valid or change data/last before its beat is accepted. Violation is flagged by a simulation-only assertion.

Optional Feature:
- NDATA_ARB_STATS_EN defined:
  - Adds output pkt_count, NUM_INPUTS x 32 bits, and input stats_clear, 1 bit.
  - pkt_count[i] increments on each accepted in_last beat of input i and wraps modulo 2^32.
  - stats_clear zeroes all counters synchronously; clear wins over a simultaneous increment.
  - Counters reset to 0.
- Undefined: the ports and counters are absent and there is no functional difference otherwise.

Decomposition:
- Shared package ndata_arb_pkg:
  - arb_state_t enum {IDLE, LOCKED}.
  - Function rr_select(req, ptr) returning the index and a found flag.
  - localparam SRC_W = $clog2(NUM_INPUTS), with a minimum of 1.
- One natural sub-module: rr_priority_picker, a combinational rotate, first-one and unrotate stage. It can be reused by other arbiters in the stream library.
- Output register stays inline.

Test Plan:
- Single source: input 2 sends a 3-beat packet with data 0x10, 0x11, 0x12 and out_ready=1 → output shows those beats on cycles t+1 to t+3, out_src=2, out_last only on 0x12, in_ready[0,1,3]=0 throughout.
- Round robin: all 4 inputs hold single-beat packets continuously from reset → out_src sequence is 0,1,2,3,0,1 with one beat per cycle and no gaps.
- Packet lock: input 0 sends 4 beats with valid low for 2 cycles after beat 2, while input 1 requests → input 1 gets no grant until beat 4 (last) of input 0 is accepted, then out_src=1 on the next output beat.
- Backpressure: out_ready=0 for 5 cycles mid-packet → out_valid stays 1 with the same data, all in_ready=0, and no beat is lost or duplicated after release.
- Reset mid-packet: rst_n=0 for 1 cycle during beat 2 of input 3 → out_valid=0 next cycle, FSM=IDLE, and the next grant comes from input 0 (rr_ptr=0).
- Stats (NDATA_ARB_STATS_EN): input 1 sends 3 packets, then stats_clear is pulsed in the same cycle as a 4th last beat → pkt_count[1] reads 3, then 0.

Source files
------------

// File: rtl/ndata_arb_pkg.sv
// Shared types and helpers for the ndata stream arbiters: FSM state,
// source-index width and a behavioural round-robin search.
package ndata_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  localparam int NUM_INPUTS_DEF = 4;
  localparam int MAX_INPUTS     = 32;

  function automatic int src_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  localparam int SRC_W = src_width(NUM_INPUTS_DEF);

  typedef struct packed {
    logic       found;
    logic [4:0] idx;
  } rr_result_t;

  // First requester at or after ptr, wrapping modulo n.
  function automatic rr_result_t rr_select(input logic [MAX_INPUTS-1:0] req,
                                           input int ptr, input int n);
    rr_result_t r;
    int j;
    r = '0;
    for (int k = MAX_INPUTS - 1; k >= 0; k--) begin
      if (k < n) begin
        j = ptr + k;
        if (j >= n) j = j - n;
        if (req[j]) begin
          r.found = 1'b1;
          r.idx   = 5'(j);
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ndata_packet_arbiter_rr_priority_picker.sv
// Combinational round-robin picker: rotate requests by ptr, find the first
// set bit, then map the offset back to an absolute index.
module rr_priority_picker #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         found_o
);

  logic [2*N-1:0] req_dbl;
  logic [N-1:0]   req_rot;
  logic [W-1:0]   off;
  logic [W:0]     sum_w;

  // Doubling the vector makes the rotate valid for any N, not only powers of two.
  assign req_dbl = {req_i, req_i};
  assign req_rot = req_dbl[ptr_i +: N];

  always_comb begin
    off     = '0;
    found_o = 1'b0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_rot[k]) begin
        off     = W'(k);
        found_o = 1'b1;
      end
    end
  end

  always_comb begin
    sum_w = {1'b0, ptr_i} + {1'b0, off};
    if (sum_w >= (W+1)'(N)) sum_w = sum_w - (W+1)'(N);
    idx_o = W'(sum_w);
  end

endmodule

// File: rtl/ndata_packet_arbiter.sv
// Packet-granular round-robin arbiter merging NUM_INPUTS ndata streams into one
// registered output. Define NDATA_ARB_STATS_EN for per-input packet counters.
module ndata_packet_arbiter
  import ndata_arb_pkg::*;
#(
  parameter type data_t       = logic [31:0],
  parameter int  NUM_INPUTS   = 4,
  parameter int  NUM_ELEMENTS = 8,
  localparam int DW           = $bits(data_t),
  localparam int BEAT_W       = NUM_ELEMENTS * DW,
  localparam int SEL_W        = src_width(NUM_INPUTS)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_INPUTS*BEAT_W-1:0]   in_data,
  input  logic [NUM_INPUTS*NUM_ELEMENTS-1:0] in_keep,
  input  logic [NUM_INPUTS-1:0]          in_last,
  input  logic [NUM_INPUTS-1:0]          in_valid,
  output logic [NUM_INPUTS-1:0]          in_ready,
  output logic [BEAT_W-1:0]              out_data,
  output logic [NUM_ELEMENTS-1:0]        out_keep,
  output logic                           out_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [SEL_W-1:0]               out_src
`ifdef NDATA_ARB_STATS_EN
  ,
  input  logic                           stats_clear,
  output logic [NUM_INPUTS*32-1:0]       pkt_count
`endif
);

  arb_state_t               state_q, state_d;
  logic [SEL_W-1:0]         rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]         grant_q, grant_d;

  logic [BEAT_W-1:0]        out_data_q;
  logic [NUM_ELEMENTS-1:0]  out_keep_q;
  logic                     out_last_q;
  logic                     out_valid_q;
  logic [SEL_W-1:0]         out_src_q;

  logic [BEAT_W-1:0]        beat_data [NUM_INPUTS];
  logic [NUM_ELEMENTS-1:0]  beat_keep [NUM_INPUTS];

  logic [SEL_W-1:0]         pick_idx;
  logic                     pick_found;
  logic [SEL_W-1:0]         sel;
  logic                     active;
  logic                     load_en;
  logic                     acc;

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_beat
    assign beat_data[gi] = in_data[gi*BEAT_W +: BEAT_W];
    assign beat_keep[gi] = in_keep[gi*NUM_ELEMENTS +: NUM_ELEMENTS];
  end

  rr_priority_picker #(
    .N (NUM_INPUTS),
    .W (SEL_W)
  ) u_picker (
    .req_i   (in_valid),
    .ptr_i   (rr_ptr_q),
    .idx_o   (pick_idx),
    .found_o (pick_found)
  );

  function automatic logic [SEL_W-1:0] next_ptr(input logic [SEL_W-1:0] p);
    return (32'(p) == NUM_INPUTS - 1) ? '0 : p + 1'b1;
  endfunction

  assign load_en = !out_valid_q || out_ready;

  always_comb begin
    sel      = grant_q;
    active   = 1'b1;
    in_ready = '0;
    if (state_q == IDLE) begin
      sel    = pick_idx;
      active = pick_found;
    end
    if (load_en && active) in_ready[sel] = 1'b1;
    acc = load_en && active && in_valid[sel];
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    case (state_q)
      IDLE: begin
        if (acc) begin
          if (in_last[sel]) begin
            rr_ptr_d = next_ptr(sel);
          end else begin
            state_d = LOCKED;
            grant_d = sel;
          end
        end
      end
      LOCKED: begin
        if (acc && in_last[sel]) begin
          state_d  = IDLE;
          rr_ptr_d = next_ptr(grant_q);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_keep_q  <= '0;
      out_src_q   <= '0;
    end else if (load_en) begin
      out_valid_q <= acc;
      if (acc) begin
        out_last_q <= in_last[sel];
        out_keep_q <= beat_keep[sel];
        out_src_q  <= sel;
      end
    end
  end

  // Data carries no reset so it maps onto plain enable flops.
  always_ff @(posedge clk) begin
    if (load_en && acc) out_data_q <= beat_data[sel];
  end

  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;
  assign out_valid = out_valid_q;
  assign out_src   = out_src_q;

`ifdef NDATA_ARB_STATS_EN
  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_stats
    logic [31:0] cnt_q;
    always_ff @(posedge clk) begin
      if (!rst_n || stats_clear) begin
        cnt_q <= '0;
      end else if (in_valid[gi] && in_ready[gi] && in_last[gi]) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
    assign pkt_count[gi*32 +: 32] = cnt_q;
  end
`else
  // Statistics counters are not built in this configuration.
`endif

  rr_result_t ref_pick;
  assign ref_pick = rr_select(MAX_INPUTS'(in_valid), int'(rr_ptr_q), NUM_INPUTS);

  a_picker: assert property (@(posedge clk) disable iff (!rst_n)
    (pick_found == ref_pick.found) && (!pick_found || 32'(pick_idx) == 32'(ref_pick.idx)));

  for (genvar gi = 0; gi < NUM_INPUTS; gi++) begin : g_proto
    a_hold: assert property (@(posedge clk) disable iff (!rst_n)
      (in_valid[gi] && !in_ready[gi]) |=>
        (in_valid[gi] && $stable(in_last[gi]) && $stable(in_data[gi*BEAT_W +: BEAT_W])));
  end

endmodule

// File: tb/tb_ndata_packet_arbiter.sv
// Directed bench for ndata_packet_arbiter: single source, round robin, packet
// lock, backpressure, reset mid-packet and (with NDATA_ARB_STATS_EN) counters.
module tb_ndata_packet_arbiter;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [1023:0]  in_data = '0;
  logic [31:0]    in_keep = '0;
  logic [3:0]     in_last = '0;
  logic [3:0]     in_valid = '0;
  logic [3:0]     in_ready;
  logic [255:0]   out_data;
  logic [7:0]     out_keep;
  logic           out_last;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [1:0]     out_src;
`ifdef NDATA_ARB_STATS_EN
  logic           stats_clear = 1'b0;
  logic [127:0]   pkt_count;
`endif

  int checks = 0;
  int errors = 0;

  ndata_packet_arbiter dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_keep   (in_keep),
    .in_last   (in_last),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_keep  (out_keep),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_src   (out_src)
`ifdef NDATA_ARB_STATS_EN
    ,
    .stats_clear (stats_clear),
    .pkt_count   (pkt_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("ok   %s value=%0h", tag, got);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Element e of each beat carries d ^ (e<<24); keep is 0xA5 ^ input index.
  task automatic set_in(input int i, input logic v, input logic [31:0] d, input logic l);
    for (int e = 0; e < 8; e++) in_data[(i*8+e)*32 +: 32] = d ^ (32'(e) << 24);
    in_keep[i*8 +: 8] = 8'hA5 ^ 8'(i);
    in_valid[i] = v;
    in_last[i]  = l;
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [31:0] d,
                         input logic l, input int src);
    if (!v) begin
      check(tag, 64'(out_valid), 64'd0);
    end else begin
      check(tag, {out_valid, out_last, out_src, out_keep, out_data[31:0]},
            {1'b1, l, 2'(src), 8'hA5 ^ 8'(src), d});
      check({tag, "_tail"}, out_data[255:224], d ^ 32'h0700_0000);
    end
  endtask

  task automatic chk_rdy(input string tag, input logic [3:0] exp);
    check(tag, 64'(in_ready), 64'(exp));
  endtask

  initial begin
    // reset state
    cyc();
    cyc();
    @(negedge clk);
    check("rst_out", {out_valid, out_last, out_src, out_keep}, 64'd0);
    chk_rdy("rst_rdy", 4'b0000);

    // single source: input 2, three beats
    cyc(); rst_n = 1'b1; set_in(2, 1, 32'h10, 0);
    @(negedge clk); chk_rdy("t1_rdy0", 4'b0100); chk_out("t1_out0", 0, 0, 0, 0);
    cyc(); set_in(2, 1, 32'h11, 0);
    @(negedge clk); chk_out("t1_b10", 1, 32'h10, 0, 2); chk_rdy("t1_rdy1", 4'b0100);
    cyc(); set_in(2, 1, 32'h12, 1);
    @(negedge clk); chk_out("t1_b11", 1, 32'h11, 0, 2); chk_rdy("t1_rdy2", 4'b0100);
    cyc(); set_in(2, 0, 32'h0, 0);
    @(negedge clk); chk_out("t1_b12", 1, 32'h12, 1, 2); chk_rdy("t1_rdy3", 4'b0000);
    cyc();
    @(negedge clk); chk_out("t1_idle", 0, 0, 0, 0);

    // round robin: all inputs hold single-beat packets from reset
    cyc();
    for (int i = 0; i < 4; i++) set_in(i, 1, 32'h20 + 32'(i), 1);
    rst_n = 1'b0;
    cyc(); rst_n = 1'b1;
    @(negedge clk); chk_rdy("t2_rdy0", 4'b0001); chk_out("t2_out0", 0, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      @(negedge clk);
      chk_out($sformatf("t2_beat%0d", k), 1, 32'h20 + 32'((k-1) % 4), 1, (k-1) % 4);
      chk_rdy($sformatf("t2_rdy%0d", k), 4'(1 << (k % 4)));
    end

    // packet lock: input 0 four beats with a 2-cycle valid gap, input 1 waiting
    cyc(); rst_n = 1'b0; in_valid = '0; in_last = '0;
    cyc(); rst_n = 1'b1; set_in(0, 1, 32'h40, 0); set_in(1, 1, 32'h31, 1);
    @(negedge clk); chk_rdy("t3_rdy0", 4'b0001);
    cyc(); set_in(0, 1, 32'h41, 0);
    @(negedge clk); chk_out("t3_b40", 1, 32'h40, 0, 0); chk_rdy("t3_rdy1", 4'b0001);
    cyc(); set_in(0, 0, 32'h0, 0);
    @(negedge clk); chk_out("t3_b41", 1, 32'h41, 0, 0); chk_rdy("t3_gap1", 4'b0001);
    cyc();
    @(negedge clk); chk_out("t3_bub1", 0, 0, 0, 0); chk_rdy("t3_gap2", 4'b0001);
    cyc(); set_in(0, 1, 32'h42, 0);
    @(negedge clk); chk_out("t3_bub2", 0, 0, 0, 0); chk_rdy("t3_rdy4", 4'b0001);
    cyc(); set_in(0, 1, 32'h43, 1);
    @(negedge clk); chk_out("t3_b42", 1, 32'h42, 0, 0); chk_rdy("t3_rdy5", 4'b0001);
    cyc(); set_in(0, 0, 32'h0, 0);
    @(negedge clk); chk_out("t3_b43", 1, 32'h43, 1, 0); chk_rdy("t3_rdy6", 4'b0010);
    cyc(); set_in(1, 0, 32'h0, 0);
    @(negedge clk); chk_out("t3_b31", 1, 32'h31, 1, 1); chk_rdy("t3_rdy7", 4'b0000);

    // backpressure: out_ready low for 5 cycles mid-packet from input 3
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; set_in(3, 1, 32'h50, 0);
    @(negedge clk); chk_rdy("t4_rdy0", 4'b1000);
    cyc(); set_in(3, 1, 32'h51, 0);
    @(negedge clk); chk_out("t4_b50", 1, 32'h50, 0, 3);
    cyc(); set_in(3, 1, 32'h52, 0); out_ready = 1'b0;
    @(negedge clk); chk_out("t4_hold0", 1, 32'h51, 0, 3); chk_rdy("t4_bp0", 4'b0000);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      @(negedge clk);
      chk_out($sformatf("t4_hold%0d", k), 1, 32'h51, 0, 3);
      chk_rdy($sformatf("t4_bp%0d", k), 4'b0000);
    end
    cyc(); out_ready = 1'b1;
    @(negedge clk); chk_out("t4_rel", 1, 32'h51, 0, 3); chk_rdy("t4_rdyrel", 4'b1000);
    cyc(); set_in(3, 1, 32'h53, 1);
    @(negedge clk); chk_out("t4_b52", 1, 32'h52, 0, 3);
    cyc(); set_in(3, 0, 32'h0, 0);
    @(negedge clk); chk_out("t4_b53", 1, 32'h53, 1, 3); chk_rdy("t4_rdyend", 4'b0000);
    cyc();
    @(negedge clk); chk_out("t4_idle", 0, 0, 0, 0);

    // reset mid-packet of input 3 after rr_ptr was moved to 2
    cyc(); set_in(1, 1, 32'h61, 1);
    @(negedge clk); chk_rdy("t5_rdy0", 4'b0010);
    cyc(); set_in(1, 0, 32'h0, 0); set_in(3, 1, 32'h62, 0);
    @(negedge clk); chk_out("t5_b61", 1, 32'h61, 1, 1); chk_rdy("t5_rdy1", 4'b1000);
    cyc(); set_in(3, 1, 32'h63, 0); rst_n = 1'b0;
    @(negedge clk); chk_out("t5_b62", 1, 32'h62, 0, 3);
    cyc(); rst_n = 1'b1; set_in(3, 1, 32'h71, 1); set_in(0, 1, 32'h70, 1);
    @(negedge clk); chk_out("t5_rstout", 0, 0, 0, 0); chk_rdy("t5_rdyrst", 4'b0001);
    cyc(); set_in(0, 0, 32'h0, 0);
    @(negedge clk); chk_out("t5_b70", 1, 32'h70, 1, 0); chk_rdy("t5_rdy3", 4'b1000);
    cyc(); set_in(3, 0, 32'h0, 0);
    @(negedge clk); chk_out("t5_b71", 1, 32'h71, 1, 3);

`ifdef NDATA_ARB_STATS_EN
    // stats: three packets from input 1, clear collides with the fourth
    cyc(); rst_n = 1'b0;
    cyc(); rst_n = 1'b1; set_in(1, 1, 32'h80, 1);
    @(negedge clk); check("t6_cnt0", 64'(pkt_count[63:32]), 64'd0);
    cyc();
    cyc();
    cyc(); stats_clear = 1'b1;
    @(negedge clk); check("t6_cnt3", 64'(pkt_count[63:32]), 64'd3);
    check("t6_cnt_in0", 64'(pkt_count[31:0]), 64'd0);
    cyc(); stats_clear = 1'b0; set_in(1, 0, 32'h0, 0);
    @(negedge clk); check("t6_clr", 64'(pkt_count[63:32]), 64'd0);
`endif

    cyc();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
